request_unit: RTL and testbench
===============================

// Module: request_unit
// PURPOSE
//  Memory request unit between the single-cycle core and one single-port RAM.
//  Arbitrates instruction fetches (imem*) and load/store accesses (dmm*) onto one RAM bus.
//  Produces the core's i_ready/d_ready strobes; i_ready is the pc module's iready.
//  Holds the last fetched instruction (imemload) and the last load data (dmmload).
// PARAMETERS
//  ADDR_W   32  address width, core side and RAM side
//  DATA_W   32  data width
//  TIMEOUT  16  max cycles waiting for ram_ack before a forced completion; 0 = never
// PORTS
//  clk        in   1       system clock, rising edge
//  nRST       in   1       asynchronous, active-low reset
//  imem_req   in   1       core requests instruction at imemaddr
//  imemaddr   in   ADDR_W  fetch address (PC)
//  imemload   out  DATA_W  registered fetched instruction
//  i_ready    out  1       1-cycle pulse: imemload updated
//  dmm_ren    in   1       load request (memRead)
//  dmm_wen    in   1       store request (memWrite)
//  dmmaddr    in   ADDR_W  load/store address (aluOut)
//  dmmstore   in   DATA_W  store data (regData2)
//  dmmload    out  DATA_W  registered load data (core memload)
//  d_ready    out  1       1-cycle pulse: data access complete
//  bus_err    out  1       1-cycle pulse, coincident with the ready that ended a timeout
//  ram_addr   out  ADDR_W  RAM address, registered
//  ram_store  out  DATA_W  RAM write data, registered
//  ram_ren    out  1       RAM read strobe, level, held until ack
//  ram_wen    out  1       RAM write strobe, level, held until ack
//  ram_load   in   DATA_W  RAM read data, valid when ram_ack=1
//  ram_ack    in   1       RAM completion, 1-cycle pulse
// BEHAVIOUR
//  Reset: state IDLE, d_done=0, timer=0; every output 0, including imemload and dmmload.
//  States:
//   IDLE  - dreq = (dmm_ren|dmm_wen) & ~d_done.
//           dreq -> DACC; else imem_req -> IFETCH; else stay.
//           Data has priority over fetch.
//   IFETCH, DACC - on entry, latch addr/data/direction into ram_*.
//           Inputs changing mid-access are ignored; strobes stay asserted.
//           ram_ack -> DONE; capture ram_load into imemload (IFETCH) or dmmload (DACC read).
//   DONE  - pulse i_ready or d_ready for 1 cycle; ram strobes 0; go to IDLE.
//  Latency: request in IDLE at cycle 0 -> strobe cycles 1..k, ack in cycle k -> ready in cycle k+1.
//   Best case: ready in cycle 2; total = ack latency + 2 cycles.
//   At least one idle cycle (DONE) separates consecutive RAM transactions.
//  Duplicate suppression (core holds memRead/memWrite for the whole instruction):
//   d_done set on d_ready; cleared on i_ready (next instruction fetched).
//   Result: exactly one RAM access per load/store instruction.
//  dmm_ren & dmm_wen both 1: treated as a write. Read data is not captured; dmmload unchanged.
//  Request dropped mid-access: the access still completes and ready still pulses (no abort).
//  ram_ack while in IDLE or DONE: ignored.
//  Timeout (TIMEOUT>0): timer counts strobe cycles, saturating, cleared on entry.
//   If no ack after TIMEOUT cycles -> DONE; captured data = 0; bus_err pulses with the ready.
//  Write completion leaves dmmload unchanged.
//  Reset mid-access: strobes drop asynchronously, ready is not pulsed, back to IDLE.
// STRUCTURE
//  request_pkg: state_t enum {IDLE, IFETCH, DACC, DONE}; a localparam for the timer width.
//  Single module with inline timer; no sub-module warranted.
// TESTING
//  1 Reset: nRST=0 in cycle 2 of IFETCH -> ram_ren drops the same cycle; all outputs 0; IDLE after release.
//  2 Fetch: imem_req=1, imemaddr=0x40, ack at cycle 3 with ram_load=0x00500093
//    -> ram_addr=0x40, ram_ren=1 cycles 1-3; imemload=0x00500093; i_ready pulses cycle 4 only.
//  3 Priority: dmm_ren=1 (addr 0x100) and imem_req=1 together in IDLE
//    -> RAM sees 0x100 read first, d_ready, then the 0x40 fetch.
//  4 Dedup: dmm_wen=1 held 20 cycles, dmmstore=0xDEADBEEF -> exactly one ram_wen transaction;
//    a second store is issued only after the next i_ready.
//  5 ren & wen both 1, addr 0x200 -> ram_wen=1, ram_ren=0; dmmload unchanged; d_ready pulses.
//  6 Timeout: TIMEOUT=8, no ack -> d_ready and bus_err in cycle 10; dmmload=0; then back to IDLE.

Source files
------------

// File: rtl/request_pkg.sv
// Shared types for the memory request unit: FSM state encoding and timer width.
package request_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DACC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/request_unit_if.sv
// Core-side and RAM-side signals of the request unit, bundled for port connection.
interface request_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Core requests (imem_req, dmm_ren, dmm_wen) are levels held until the matching
    // one-cycle ready pulse; ram_ren/ram_wen are levels held until the one-cycle ram_ack.
    logic              imem_req;
    logic [ADDR_W-1:0] imemaddr;
    logic [DATA_W-1:0] imemload;
    logic              i_ready;
    logic              dmm_ren;
    logic              dmm_wen;
    logic [ADDR_W-1:0] dmmaddr;
    logic [DATA_W-1:0] dmmstore;
    logic [DATA_W-1:0] dmmload;
    logic              d_ready;
    logic              bus_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic              ram_ren;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_load;
    logic              ram_ack;

    modport master (
        input  imem_req, imemaddr, dmm_ren, dmm_wen, dmmaddr, dmmstore, ram_load, ram_ack,
        output imemload, i_ready, dmmload, d_ready, bus_err,
               ram_addr, ram_store, ram_ren, ram_wen
    );

    modport slave (
        output imem_req, imemaddr, dmm_ren, dmm_wen, dmmaddr, dmmstore, ram_load, ram_ack,
        input  imemload, i_ready, dmmload, d_ready, bus_err,
               ram_addr, ram_store, ram_ren, ram_wen
    );

endinterface

// File: rtl/request_unit.sv
// Arbitrates instruction fetches and load/store accesses of a single-cycle core onto
// one single-port RAM, with data priority, per-instruction duplicate suppression and timeout.
module request_unit
    import request_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           nRST,
    request_unit_if.master bus,
    output state_t         dbg_state
);

    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT);

    state_t              state;
    logic                d_done;
    logic [TIMER_W-1:0]  timer;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_store;
    logic [DATA_W-1:0]   imemload;
    logic [DATA_W-1:0]   dmmload;
    logic                ram_ren;
    logic                ram_wen;
    logic                i_ready;
    logic                d_ready;
    logic                bus_err;
    logic                dreq;
    logic                expired;

    // d_done blocks a second access for the same held load/store until the next fetch.
    assign dreq    = (bus.dmm_ren | bus.dmm_wen) & ~d_done;
    assign expired = (TIMEOUT != 0) && (timer >= TIMER_LIMIT);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            d_done    <= 1'b0;
            timer     <= '0;
            ram_addr  <= '0;
            ram_store <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            imemload  <= '0;
            dmmload   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (dreq) begin
                        state     <= DACC;
                        ram_addr  <= bus.dmmaddr;
                        ram_store <= bus.dmmstore;
                        ram_wen   <= bus.dmm_wen;
                        ram_ren   <= ~bus.dmm_wen;
                        timer     <= '0;
                    end else if (bus.imem_req) begin
                        state     <= IFETCH;
                        ram_addr  <= bus.imemaddr;
                        ram_store <= '0;
                        ram_wen   <= 1'b0;
                        ram_ren   <= 1'b1;
                        timer     <= '0;
                    end
                end
                IFETCH, DACC: begin
                    // A real ack in the same cycle as the timeout wins.
                    if (bus.ram_ack || expired) begin
                        state   <= DONE;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        bus_err <= ~bus.ram_ack;
                        if (state == IFETCH) begin
                            imemload <= bus.ram_ack ? bus.ram_load : '0;
                            i_ready  <= 1'b1;
                            d_done   <= 1'b0;
                        end else begin
                            if (!ram_wen) begin
                                dmmload <= bus.ram_ack ? bus.ram_load : '0;
                            end
                            d_ready <= 1'b1;
                            d_done  <= 1'b1;
                        end
                    end else if (timer != {TIMER_W{1'b1}}) begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = ram_addr;
    assign bus.ram_store = ram_store;
    assign bus.ram_ren   = ram_ren;
    assign bus.ram_wen   = ram_wen;
    assign bus.imemload  = imemload;
    assign bus.dmmload   = dmmload;
    assign bus.i_ready   = i_ready;
    assign bus.d_ready   = d_ready;
    assign bus.bus_err   = bus_err;
    assign dbg_state     = state;

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: directed vector table, hand-written corner sequences and a
// randomized core/RAM run checked against a transaction-level model.
module tb_request_unit;
    import request_pkg::*;

    localparam int TMO = 8;
    localparam logic [1:0] K_FETCH = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2;

    logic   clk = 1'b0;
    logic   nRST = 1'b0;
    state_t dbg_state;

    request_unit_if bus ();

    request_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [65:0] exp_q[$];
    bit mon_en = 1'b0;
    bit auto_ack = 1'b0;
    logic dir_ack = 1'b0;
    logic [31:0] dir_load = '0;
    int store_cnt = 0;
    int wait_cnt = 0;
    logic mon_prev = 1'b0;
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct {
        string       name;
        logic        ireq, ren, wen;
        logic [31:0] iaddr, daddr, store, load;
        int          lat;
        logic        exp_ren, exp_wen, exp_i;
        logic [31:0] exp_addr, exp_data;
        int          exp_rdy;
        logic        exp_err;
    } vec_t;
    vec_t vecs[9];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_imemload"}, bus.imemload, 0);
        chk({tag, "_dmmload"}, bus.dmmload, 0);
        chk({tag, "_ready"}, {bus.i_ready, bus.d_ready, bus.bus_err}, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_store"}, bus.ram_store, 0);
        chk({tag, "_strobes"}, {bus.ram_ren, bus.ram_wen}, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_req = 1'b0; bus.imemaddr = '0;
        bus.dmm_ren  = 1'b0; bus.dmm_wen  = 1'b0;
        bus.dmmaddr  = '0;   bus.dmmstore = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        dir_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    // RAM model: ack/load are driven only here, 2 time units after the edge.
    initial begin
        bus.ram_ack = 1'b0;
        bus.ram_load = '0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_ack) begin
                bus.ram_ack = 1'b0;
                if ((bus.ram_ren || bus.ram_wen) && nRST) begin
                    if (wait_cnt == 0) begin
                        bus.ram_ack = 1'b1;
                        if (bus.ram_wen) ram_mem[bus.ram_addr] = bus.ram_store;
                        else bus.ram_load = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr]
                                                                         : dflt(bus.ram_addr);
                        wait_cnt = $urandom_range(0, 3);
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                bus.ram_ack = dir_ack;
                bus.ram_load = dir_load;
            end
        end
    end

    // Each new RAM transaction is matched against the next expected access.
    initial begin
        logic [65:0] e;
        logic cur;
        forever begin
            @(negedge clk);
            cur = bus.ram_ren | bus.ram_wen;
            if (mon_en && cur && !mon_prev) begin
                if (bus.ram_wen) store_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL txn_unexpected: got access at %0h, expected none", bus.ram_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_dir", {bus.ram_ren, bus.ram_wen}, (e[65:64] == K_STORE) ? 2'b01 : 2'b10);
                    chk("txn_addr", bus.ram_addr, e[63:32]);
                    if (e[65:64] == K_STORE) chk("txn_data", bus.ram_store, e[31:0]);
                end
            end
            mon_prev = cur;
        end
    end

    task automatic set_vec(input int i, input string nm, input logic ireq, ren, wen,
                           input logic [31:0] iaddr, daddr, store, load, input int lat,
                           input logic er, ew, ei, input logic [31:0] ea, ed,
                           input int rdy, input logic err);
        vecs[i].name = nm; vecs[i].ireq = ireq; vecs[i].ren = ren; vecs[i].wen = wen;
        vecs[i].iaddr = iaddr; vecs[i].daddr = daddr; vecs[i].store = store;
        vecs[i].load = load; vecs[i].lat = lat; vecs[i].exp_ren = er; vecs[i].exp_wen = ew;
        vecs[i].exp_i = ei; vecs[i].exp_addr = ea; vecs[i].exp_data = ed;
        vecs[i].exp_rdy = rdy; vecs[i].exp_err = err;
    endtask

    task automatic run_vec(input vec_t v);
        logic strobe;
        do_reset();
        bus.imem_req = v.ireq; bus.imemaddr = v.iaddr;
        bus.dmm_ren = v.ren; bus.dmm_wen = v.wen;
        bus.dmmaddr = v.daddr; bus.dmmstore = v.store;
        for (int c = 1; c <= v.exp_rdy + 1; c++) begin
            step();
            if (c == 1) begin
                clear_inputs();
                bus.imemaddr = ~v.iaddr; bus.dmmaddr = ~v.daddr; bus.dmmstore = ~v.store;
            end
            dir_ack = (v.lat != 0) && (c == v.lat);
            dir_load = dir_ack ? v.load : 32'hBAD0_BAD0;
            @(negedge clk);
            strobe = (c < v.exp_rdy);
            chk({v.name, "_ram_ren"}, bus.ram_ren, strobe & v.exp_ren);
            chk({v.name, "_ram_wen"}, bus.ram_wen, strobe & v.exp_wen);
            chk({v.name, "_i_ready"}, bus.i_ready, (c == v.exp_rdy) && v.exp_i);
            chk({v.name, "_d_ready"}, bus.d_ready, (c == v.exp_rdy) && !v.exp_i);
            chk({v.name, "_bus_err"}, bus.bus_err, (c == v.exp_rdy) && v.exp_err);
            if (c == 1) begin
                chk({v.name, "_ram_addr"}, bus.ram_addr, v.exp_addr);
                if (v.exp_wen) chk({v.name, "_ram_store"}, bus.ram_store, v.store);
            end
            if (c == v.exp_rdy)
                chk({v.name, "_load"}, v.exp_i ? bus.imemload : bus.dmmload, v.exp_data);
            if (c == v.exp_rdy + 1) chk({v.name, "_idle"}, dbg_state, IDLE);
        end
        dir_ack = 1'b0;
    endtask

    initial begin
        int d_cyc, i_cyc, d_cnt, base, op, exp_d;
        bit got_i;
        logic [31:0] pc, addr, data, exp_dmm;

        clear_inputs();
        @(negedge clk);
        chk_zero("reset");

        // Directed vectors: ready cycle counted from the request cycle (cycle 0).
        set_vec(0, "fetch",    1, 0, 0, 32'h40, 0, 0, 32'h0050_0093, 3, 1, 0, 1, 32'h40, 32'h0050_0093, 4, 0);
        set_vec(1, "load",     0, 1, 0, 0, 32'h100, 0, 32'h1234_5678, 1, 1, 0, 0, 32'h100, 32'h1234_5678, 2, 0);
        set_vec(2, "store",    0, 0, 1, 0, 32'h104, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 0, 1, 0, 32'h104, 0, 3, 0);
        set_vec(3, "rw_both",  0, 1, 1, 0, 32'h200, 32'hCAFE_F00D, 32'h1111_2222, 2, 0, 1, 0, 32'h200, 0, 3, 0);
        set_vec(4, "priority", 1, 1, 0, 32'h40, 32'h100, 0, 32'hA5A5_A5A5, 1, 1, 0, 0, 32'h100, 32'hA5A5_A5A5, 2, 0);
        set_vec(5, "tmo_load", 0, 1, 0, 0, 32'h300, 0, 0, 0, 1, 0, 0, 32'h300, 0, TMO + 2, 1);
        set_vec(6, "tmo_fetch",1, 0, 0, 32'h80, 0, 0, 0, 0, 1, 0, 1, 32'h80, 0, TMO + 2, 1);
        set_vec(7, "ack_at_limit", 0, 1, 0, 0, 32'h304, 0, 32'h0BAD_F00D, TMO + 1, 1, 0, 0, 32'h304, 32'h0BAD_F00D, TMO + 2, 0);
        set_vec(8, "fetch_top",1, 0, 0, 32'hFFFF_FFFC, 0, 0, 32'h13, 8, 1, 0, 1, 32'hFFFF_FFFC, 32'h13, 9, 0);
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the second strobe cycle of a fetch.
        do_reset();
        bus.imem_req = 1'b1; bus.imemaddr = 32'h40;
        step(); dir_ack = 1'b1; dir_load = 32'h77;
        step(); dir_ack = 1'b0;
        step();
        step();
        step();
        chk("rst_pre_ren", bus.ram_ren, 1);
        chk("rst_pre_imemload", bus.imemload, 32'h77);
        nRST = 1'b0;
        #1;
        chk_zero("rst_mid");
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_hold_ready", {bus.i_ready, bus.ram_ren}, 0);
        end
        step();
        nRST = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", dbg_state, IDLE);
        chk("rst_release_ren", bus.ram_ren, 0);

        // Data before fetch when both are requested together.
        do_reset();
        mon_en = 1'b1; auto_ack = 1'b1;
        exp_q.push_back({K_LOAD, 32'h100, 32'h0});
        exp_q.push_back({K_FETCH, 32'h40, 32'h0});
        bus.dmm_ren = 1'b1; bus.dmmaddr = 32'h100; bus.imem_req = 1'b1; bus.imemaddr = 32'h40;
        d_cyc = -1; i_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.d_ready && d_cyc < 0) d_cyc = c;
            if (bus.i_ready) begin i_cyc = c; break; end
        end
        chk("prio_fetch_done", i_cyc >= 0, 1);
        chk("prio_data_first", (d_cyc >= 0) && (d_cyc < i_cyc), 1);
        step(); clear_inputs();
        repeat (3) step();
        chk("prio_queue_empty", exp_q.size(), 0);

        // A store held for 20 cycles is issued once, then again only after the next fetch.
        do_reset();
        base = store_cnt; d_cnt = 0;
        exp_q.push_back({K_STORE, 32'h10, 32'hDEAD_BEEF});
        bus.dmm_wen = 1'b1; bus.dmmaddr = 32'h10; bus.dmmstore = 32'hDEAD_BEEF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.d_ready) d_cnt++;
        end
        chk("dedup_one_store", store_cnt - base, 1);
        chk("dedup_one_ready", d_cnt, 1);
        exp_q.push_back({K_FETCH, 32'h44, 32'h0});
        exp_q.push_back({K_STORE, 32'h10, 32'hDEAD_BEEF});
        step(); bus.imem_req = 1'b1; bus.imemaddr = 32'h44;
        got_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.i_ready) begin got_i = 1'b1; break; end
        end
        chk("dedup_fetch_done", got_i, 1);
        step(); bus.imem_req = 1'b0;
        repeat (12) step();
        chk("dedup_second_store", store_cnt - base, 2);
        chk("dedup_queue_empty", exp_q.size(), 0);
        clear_inputs();

        // Randomized core: one fetch per instruction plus an optional load/store.
        do_reset();
        ram_mem.delete(); ref_mem.delete();
        exp_dmm = '0; exp_d = 0;
        pc = $urandom_range(1024, 4095) * 4;
        exp_q.push_back({K_FETCH, pc, 32'h0});
        bus.imem_req = 1'b1; bus.imemaddr = pc;
        for (int n = 0; n <= 60; n++) begin
            got_i = 1'b0; d_cnt = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (bus.d_ready) begin
                    d_cnt++;
                    chk("rnd_dmmload", bus.dmmload, exp_dmm);
                end
                if (bus.i_ready) begin
                    got_i = 1'b1;
                    chk("rnd_imemload", bus.imemload, ref_rd(pc));
                    break;
                end
            end
            chk("rnd_fetch_done", got_i, 1);
            chk("rnd_d_ready_count", d_cnt, exp_d);
            if (!got_i || n == 60) break;
            step();
            op = $urandom_range(0, 3);
            addr = $urandom_range(0, 15) * 4;
            data = $urandom;
            bus.dmm_ren = (op == 1) || (op == 3);
            bus.dmm_wen = (op >= 2);
            bus.dmmaddr = addr; bus.dmmstore = data;
            exp_d = (op != 0) ? 1 : 0;
            if (op == 1) begin
                exp_q.push_back({K_LOAD, addr, 32'h0});
                exp_dmm = ref_rd(addr);
            end else if (op >= 2) begin
                exp_q.push_back({K_STORE, addr, data});
                ref_mem[addr] = data;
            end
            pc = ($urandom_range(0, 1) == 0) ? pc + 4 : $urandom_range(1024, 4095) * 4;
            exp_q.push_back({K_FETCH, pc, 32'h0});
            bus.imemaddr = pc;
        end
        step(); clear_inputs();
        repeat (5) step();
        chk("rnd_queue_empty", exp_q.size(), 0);
        mon_en = 1'b0; auto_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
